// File: rtl/npc_pkg.sv
// Shared types and defaults for the next-PC sequencer: FSM states,
// reset/exception addresses and the redirect request-select encoding.
package npc_pkg;

  localparam logic [31:0] NPC_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] NPC_EXC_VECTOR = 32'h0000_4180;

  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } npc_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_ERET = 3'd5
  } npc_sel_t;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational target arithmetic: PC+4, pseudo-direct jump target and
// PC-relative branch target, all 32-bit wrapping.
module npc_target_calc (
  input  logic [31:0] pc_out,
  input  logic [25:0] jump_idx,
  input  logic [15:0] branch_off,
  output logic [31:0] pc_plus4,
  output logic [31:0] j_target,
  output logic [31:0] br_target
);

  assign pc_plus4  = pc_out + 32'd4;
  assign j_target  = {pc_plus4[31:28], jump_idx, 2'b00};
  assign br_target = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};

endmodule

// File: rtl/npc_sequencer.sv
// Program counter owner: fixed-priority redirect select, optional branch
// delay slot, registered redirect / addr_err pulses.
//
//   state | meaning
//   SEQ   | normal fetch; redirects accepted
//   SLOT  | fetching the delay slot; pending target loads next
module npc_sequencer
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = NPC_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = NPC_EXC_VECTOR,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_req,
  input  logic [25:0] jump_idx,
  input  logic        branch_req,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        in_slot,
  output logic        addr_err
);

  npc_state_t  state, state_next;
  npc_sel_t    sel;
  logic [31:0] j_target, br_target, target;
  logic [31:0] pend_target, pend_next, pc_next;
  logic        slot_next, redirect_next, addr_err_next, misaligned;

  npc_target_calc u_calc (
    .pc_out    (pc_out),
    .jump_idx  (jump_idx),
    .branch_off(branch_off),
    .pc_plus4  (pc_plus4),
    .j_target  (j_target),
    .br_target (br_target)
  );

  // Control transfers are only accepted in SEQ; inside a slot they are dropped.
  always_comb begin
    sel = SEL_SEQ;
    if (exc_req)                              sel = SEL_EXC;
    else if (eret_req)                        sel = SEL_ERET;
    else if (state == SEQ) begin
      if (jr_req)                             sel = SEL_JR;
      else if (jump_req)                      sel = SEL_J;
      else if (branch_req && branch_taken)    sel = SEL_BR;
    end
  end

  assign misaligned = (sel == SEL_JR   && jr_addr[1:0] != 2'b00) ||
                      (sel == SEL_ERET && epc[1:0]     != 2'b00);

  always_comb begin
    case (sel)
      SEL_JR:  target = jr_addr;
      SEL_J:   target = j_target;
      SEL_BR:  target = br_target;
      default: target = pc_plus4;
    endcase
  end

  always_comb begin
    pc_next       = pc_plus4;
    state_next    = state;
    pend_next     = pend_target;
    slot_next     = 1'b0;
    redirect_next = 1'b0;
    addr_err_next = 1'b0;
    if (misaligned || sel == SEL_EXC || sel == SEL_ERET) begin
      pc_next       = (misaligned || sel == SEL_EXC) ? EXC_VECTOR : epc;
      state_next    = SEQ;
      pend_next     = '0;
      redirect_next = 1'b1;
      addr_err_next = misaligned;
    end else if (sel != SEL_SEQ) begin
      if (DELAY_SLOT != 0) begin
        pend_next  = target;
        state_next = SLOT;
        slot_next  = 1'b1;
      end else begin
        pc_next       = target;
        redirect_next = 1'b1;
      end
    end else if (state == SLOT) begin
      pc_next       = pend_target;
      state_next    = SEQ;
      pend_next     = '0;
      redirect_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEQ;
      pc_out      <= RESET_PC;
      pend_target <= '0;
      redirect    <= 1'b0;
      in_slot     <= 1'b0;
      addr_err    <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state       <= state_next;
      pc_out      <= pc_next;
      pend_target <= pend_next;
      redirect    <= redirect_next;
      in_slot     <= slot_next;
      addr_err    <= addr_err_next;
    end
  end

endmodule

// File: tb/tb_npc_sequencer.sv
// Bench for npc_sequencer: directed scenarios plus randomized traffic against
// a reference model, with one delay-slot instance and one immediate instance.
module tb_npc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, jump_req, branch_req, branch_taken, jr_req, exc_req, eret_req;
  logic [25:0] jump_idx;
  logic [15:0] branch_off;
  logic [31:0] jr_addr, epc;

  logic [31:0] pc_o [2];
  logic [31:0] p4_o [2];
  logic        rd_o [2];
  logic        sl_o [2];
  logic        ae_o [2];

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_pc [2];
  logic [31:0] m_tgt [2];
  bit          m_pend [2];
  bit          m_slot [2];
  bit          m_rd [2];
  bit          m_ae [2];

  always #5 clk = ~clk;

  npc_sequencer #(.DELAY_SLOT(1)) dut_ds (
    .clk(clk), .reset(reset), .stall(stall),
    .jump_req(jump_req), .jump_idx(jump_idx),
    .branch_req(branch_req), .branch_taken(branch_taken), .branch_off(branch_off),
    .jr_req(jr_req), .jr_addr(jr_addr), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc_out(pc_o[0]), .pc_plus4(p4_o[0]), .redirect(rd_o[0]), .in_slot(sl_o[0]),
    .addr_err(ae_o[0])
  );

  npc_sequencer #(.DELAY_SLOT(0)) dut_imm (
    .clk(clk), .reset(reset), .stall(stall),
    .jump_req(jump_req), .jump_idx(jump_idx),
    .branch_req(branch_req), .branch_taken(branch_taken), .branch_off(branch_off),
    .jr_req(jr_req), .jr_addr(jr_addr), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc_out(pc_o[1]), .pc_plus4(p4_o[1]), .redirect(rd_o[1]), .in_slot(sl_o[1]),
    .addr_err(ae_o[1])
  );

  // Reference model: one step per clock, from the architectural rules.
  task automatic model_step(input int k, input bit ds);
    logic [31:0] p4, t;
    p4 = m_pc[k] + 32'd4;
    m_rd[k] = 1'b0;
    m_ae[k] = 1'b0;
    if (reset) begin
      m_pc[k] = 32'h3000; m_pend[k] = 1'b0; m_slot[k] = 1'b0;
    end else if (!stall) begin
      if (exc_req) begin
        m_pc[k] = 32'h4180; m_rd[k] = 1'b1; m_pend[k] = 1'b0; m_slot[k] = 1'b0;
      end else if (eret_req) begin
        m_ae[k] = (epc % 4) != 0;
        m_pc[k] = m_ae[k] ? 32'h4180 : epc;
        m_rd[k] = 1'b1; m_pend[k] = 1'b0; m_slot[k] = 1'b0;
      end else if (m_pend[k]) begin
        m_pc[k] = m_tgt[k]; m_rd[k] = 1'b1; m_pend[k] = 1'b0; m_slot[k] = 1'b0;
      end else if (jr_req && (jr_addr % 4) != 0) begin
        m_pc[k] = 32'h4180; m_rd[k] = 1'b1; m_ae[k] = 1'b1;
      end else if (jr_req || jump_req || (branch_req && branch_taken)) begin
        if (jr_req)        t = jr_addr;
        else if (jump_req) t = (p4 & 32'hF000_0000) + 32'(jump_idx) * 4;
        else               t = p4 + 32'(int'($signed(branch_off)) * 4);
        if (ds) begin
          m_tgt[k] = t; m_pend[k] = 1'b1; m_slot[k] = 1'b1; m_pc[k] = p4;
        end else begin
          m_pc[k] = t; m_rd[k] = 1'b1;
        end
      end else begin
        m_pc[k] = p4;
      end
    end
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; jump_req = 0; branch_req = 0; branch_taken = 0;
    jr_req = 0; exc_req = 0; eret_req = 0;
    jump_idx = '0; branch_off = '0; jr_addr = '0; epc = '0;
  endtask

  task automatic tick();
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (pc_o[0] !== 32'h3000 || pc_o[1] !== 32'h3000) begin
      errors++; $display("FAIL reset_pc: got %h/%h want 00003000", pc_o[0], pc_o[1]);
    end
    vectors++;
    if (rd_o[0] !== 1'b0 || sl_o[0] !== 1'b0 || ae_o[0] !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got rd=%b slot=%b ae=%b want 000", rd_o[0], sl_o[0], ae_o[0]);
    end
    vectors++;
    if (p4_o[0] !== 32'h3004) begin
      errors++; $display("FAIL reset_plus4: got %h want 00003004", p4_o[0]);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (pc_o[0] !== 32'h3000 + 32'(4 * i) || rd_o[0] !== 1'b0 || sl_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL seq_%0d: got pc=%h rd=%b slot=%b want pc=%h rd=0 slot=0",
                 i, pc_o[0], rd_o[0], sl_o[0], 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump();
    tick();
    jump_req = 1; jump_idx = 26'h0000C40;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h3014 || sl_o[0] !== 1'b1 || rd_o[0] !== 1'b0) begin
      errors++; $display("FAIL jump_slot: got pc=%h slot=%b rd=%b want 00003014 1 0", pc_o[0], sl_o[0], rd_o[0]);
    end
    vectors++;
    if (pc_o[1] !== 32'h3100 || rd_o[1] !== 1'b1 || sl_o[1] !== 1'b0) begin
      errors++; $display("FAIL jump_imm: got pc=%h rd=%b slot=%b want 00003100 1 0", pc_o[1], rd_o[1], sl_o[1]);
    end
    tick();
    vectors++;
    if (pc_o[0] !== 32'h3100 || rd_o[0] !== 1'b1 || sl_o[0] !== 1'b0) begin
      errors++; $display("FAIL jump_target: got pc=%h rd=%b slot=%b want 00003100 1 0", pc_o[0], rd_o[0], sl_o[0]);
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (8) tick();
    branch_req = 1; branch_taken = 1; branch_off = 16'hFFFC;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h3024 || sl_o[0] !== 1'b1) begin
      errors++; $display("FAIL branch_slot: got pc=%h slot=%b want 00003024 1", pc_o[0], sl_o[0]);
    end
    vectors++;
    if (pc_o[1] !== 32'h3014 || rd_o[1] !== 1'b1) begin
      errors++; $display("FAIL branch_imm: got pc=%h rd=%b want 00003014 1", pc_o[1], rd_o[1]);
    end
    tick();
    vectors++;
    if (pc_o[0] !== 32'h3014 || rd_o[0] !== 1'b1) begin
      errors++; $display("FAIL branch_target: got pc=%h rd=%b want 00003014 1", pc_o[0], rd_o[0]);
    end
    do_reset();
    repeat (8) tick();
    branch_req = 1; branch_taken = 0; branch_off = 16'hFFFC;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h3024 || sl_o[0] !== 1'b0 || rd_o[0] !== 1'b0) begin
      errors++; $display("FAIL branch_nt: got pc=%h slot=%b rd=%b want 00003024 0 0", pc_o[0], sl_o[0], rd_o[0]);
    end
    tick();
    vectors++;
    if (pc_o[0] !== 32'h3028) begin
      errors++; $display("FAIL branch_nt_next: got %h want 00003028", pc_o[0]);
    end
  endtask

  task automatic test_priority();
    do_reset();
    jr_req = 1; jr_addr = 32'h0000_5000; jump_req = 1; jump_idx = 26'h123; exc_req = 1;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h4180 || rd_o[0] !== 1'b1 || sl_o[0] !== 1'b0 || ae_o[0] !== 1'b0) begin
      errors++; $display("FAIL prio_exc: got pc=%h rd=%b slot=%b ae=%b want 00004180 1 0 0",
                         pc_o[0], rd_o[0], sl_o[0], ae_o[0]);
    end
    jr_req = 1; jr_addr = 32'h0000_3002;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h4180 || ae_o[0] !== 1'b1 || sl_o[0] !== 1'b0) begin
      errors++; $display("FAIL jr_misaligned: got pc=%h ae=%b slot=%b want 00004180 1 0", pc_o[0], ae_o[0], sl_o[0]);
    end
    eret_req = 1; epc = 32'h0000_3abc; jr_req = 1; jr_addr = 32'h0000_7000;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h3abc || pc_o[1] !== 32'h3abc || rd_o[0] !== 1'b1 || ae_o[0] !== 1'b0) begin
      errors++; $display("FAIL eret: got pc=%h/%h rd=%b ae=%b want 00003abc 1 0", pc_o[0], pc_o[1], rd_o[0], ae_o[0]);
    end
    tick();
    vectors++;
    if (rd_o[0] !== 1'b0 || ae_o[0] !== 1'b0) begin
      errors++; $display("FAIL pulse_width: got rd=%b ae=%b want 0 0", rd_o[0], ae_o[0]);
    end
  endtask

  task automatic test_stall_slot();
    do_reset();
    jump_req = 1; jump_idx = 26'h0000C40;
    tick();
    idle_inputs();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc_o[0] !== 32'h3004 || sl_o[0] !== 1'b1 || rd_o[0] !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: got pc=%h slot=%b rd=%b want 00003004 1 0",
                           i, pc_o[0], sl_o[0], rd_o[0]);
      end
    end
    stall = 0;
    tick();
    vectors++;
    if (pc_o[0] !== 32'h3100 || rd_o[0] !== 1'b1 || sl_o[0] !== 1'b0) begin
      errors++; $display("FAIL stall_release: got pc=%h rd=%b slot=%b want 00003100 1 0", pc_o[0], rd_o[0], sl_o[0]);
    end
  endtask

  task automatic test_reset_in_slot();
    do_reset();
    jump_req = 1; jump_idx = 26'h0000C40;
    tick();
    idle_inputs();
    stall = 1; reset = 1;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'h3000 || sl_o[0] !== 1'b0 || rd_o[0] !== 1'b0) begin
      errors++; $display("FAIL reset_slot: got pc=%h slot=%b rd=%b want 00003000 0 0", pc_o[0], sl_o[0], rd_o[0]);
    end
    tick();
    vectors++;
    if (pc_o[0] !== 32'h3004 || rd_o[0] !== 1'b0) begin
      errors++; $display("FAIL reset_slot_drop: got pc=%h rd=%b want 00003004 0", pc_o[0], rd_o[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 59) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      exc_req      = ($urandom_range(0, 15) == 0);
      eret_req     = ($urandom_range(0, 11) == 0);
      jr_req       = ($urandom_range(0, 5) == 0);
      jump_req     = ($urandom_range(0, 4) == 0);
      branch_req   = ($urandom_range(0, 3) == 0);
      branch_taken = $urandom_range(0, 1) == 1;
      jump_idx     = 26'($urandom);
      branch_off   = 16'($urandom);
      jr_addr      = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      epc          = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (pc_o[k] !== m_pc[k] || p4_o[k] !== m_pc[k] + 32'd4 || rd_o[k] !== m_rd[k] ||
            sl_o[k] !== m_slot[k] || ae_o[k] !== m_ae[k]) begin
          errors++;
          $display("FAIL rand_%0d_dut%0d: got pc=%h p4=%h rd=%b slot=%b ae=%b want pc=%h rd=%b slot=%b ae=%b",
                   n, k, pc_o[k], p4_o[k], rd_o[k], sl_o[k], ae_o[k],
                   m_pc[k], m_rd[k], m_slot[k], m_ae[k]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    eret_req = 1; epc = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    vectors++;
    if (pc_o[0] !== 32'hFFFF_FFFC || p4_o[0] !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_plus4: got pc=%h p4=%h want fffffffc 00000000", pc_o[0], p4_o[0]);
    end
    tick();
    vectors++;
    if (pc_o[0] !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_pc: got %h want 00000000", pc_o[0]);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_priority();
    test_stall_slot();
    test_reset_in_slot();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
